// File: rtl/frame_bank_scheduler_if.sv
// ============================================================================
// Module   : frame_bank_scheduler_if
// Brief    : Loader and consumer handshake bundle for frame_bank_scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface frame_bank_scheduler_if #(
    parameter int COUNT_WIDTH = 16
) ();
    logic                   ENABLE_I;
    logic                   LOAD_DONE_I;
    logic                   LOAD_START_O;
    logic                   LOAD_BANK_O;
    logic                   FRAME_READY_O;
    logic                   FRAME_BANK_O;
    logic                   FRAME_ACK_I;
    logic                   FRAME_RELEASE_I;
    logic                   BUSY_O;
    logic                   TIMEOUT_O;
    logic                   PROTO_ERR_O;
    logic [COUNT_WIDTH-1:0] FRAME_COUNT_O;

    modport slave (
        input  ENABLE_I, LOAD_DONE_I, FRAME_ACK_I, FRAME_RELEASE_I,
        output LOAD_START_O, LOAD_BANK_O, FRAME_READY_O, FRAME_BANK_O,
               BUSY_O, TIMEOUT_O, PROTO_ERR_O, FRAME_COUNT_O
    );

    modport master (
        output ENABLE_I, LOAD_DONE_I, FRAME_ACK_I, FRAME_RELEASE_I,
        input  LOAD_START_O, LOAD_BANK_O, FRAME_READY_O, FRAME_BANK_O,
               BUSY_O, TIMEOUT_O, PROTO_ERR_O, FRAME_COUNT_O
    );
endinterface

`default_nettype wire

// File: rtl/frame_bank_scheduler.sv
// ============================================================================
// Module   : frame_bank_scheduler
// Brief    : Ping-pong bank scheduler for the frame loader with watchdog.
// Revision : 1.0
// ============================================================================
`default_nettype none

module frame_bank_scheduler #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMEOUT_WIDTH  = 11,
    parameter int COUNT_WIDTH    = 16
) (
    input wire                    CLOCK_I,
    input wire                    RESET_I,
    frame_bank_scheduler_if.slave bus
);
    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_WAIT_LOW  = 2'd1;
    localparam logic [1:0] c_WAIT_HIGH = 2'd2;
    localparam logic [1:0] c_FAULT     = 2'd3;

    localparam logic [1:0] c_EMPTY  = 2'd0;
    localparam logic [1:0] c_FULL   = 2'd1;
    localparam logic [1:0] c_IN_USE = 2'd2;

    localparam logic [TIMEOUT_WIDTH-1:0] c_WDOG_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [1:0]               state_q, state_d;
    logic [1:0][1:0]          bank_q, bank_d;
    logic                     wr_ptr_q, wr_ptr_d;
    logic                     rd_ptr_q, rd_ptr_d;
    logic                     held_q, held_d;
    logic                     held_bank_q, held_bank_d;
    logic [TIMEOUT_WIDTH-1:0] wdog_q, wdog_d;
    logic                     start_q, start_d;
    logic                     timeout_q, timeout_d;
    logic                     proto_err_q, proto_err_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;

    logic                     w_load_done;
    logic                     w_frame_ready;

    always_ff @(posedge CLOCK_I or posedge RESET_I) begin
        if (RESET_I) begin
            state_q     <= c_IDLE;
            bank_q      <= {c_EMPTY, c_EMPTY};
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            held_q      <= 1'b0;
            held_bank_q <= 1'b0;
            wdog_q      <= '0;
            start_q     <= 1'b0;
            timeout_q   <= 1'b0;
            proto_err_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            held_q      <= held_d;
            held_bank_q <= held_bank_d;
            wdog_q      <= wdog_d;
            start_q     <= start_d;
            timeout_q   <= timeout_d;
            proto_err_q <= proto_err_d;
            count_q     <= count_d;
        end
    end

    // Load sequencing: a bank only turns FULL once DONE has gone low then high.
    always_comb begin
        state_d     = state_q;
        wdog_d      = wdog_q;
        start_d     = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        timeout_d   = timeout_q;
        w_load_done = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (bus.ENABLE_I && (bank_q[wr_ptr_q] == c_EMPTY) && bus.LOAD_DONE_I) begin
                    start_d = 1'b1;
                    state_d = c_WAIT_LOW;
                    wdog_d  = '0;
                end
            end
            c_WAIT_LOW: begin
                if (!bus.LOAD_DONE_I) begin
                    state_d = c_WAIT_HIGH;
                    wdog_d  = '0;
                end else if (wdog_q == c_WDOG_LAST) begin
                    state_d   = c_FAULT;
                    timeout_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            c_WAIT_HIGH: begin
                if (bus.LOAD_DONE_I) begin
                    state_d     = c_IDLE;
                    wr_ptr_d    = ~wr_ptr_q;
                    count_d     = count_q + 1'b1;
                    w_load_done = 1'b1;
                end else if (wdog_q == c_WDOG_LAST) begin
                    state_d   = c_FAULT;
                    timeout_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            c_FAULT: begin
                if (!bus.ENABLE_I) begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    // Release and acquire never collide: READY is low whenever a bank is held.
    always_comb begin
        bank_d      = bank_q;
        rd_ptr_d    = rd_ptr_q;
        held_d      = held_q;
        held_bank_d = held_bank_q;
        proto_err_d = proto_err_q;
        if (w_load_done) begin
            bank_d[wr_ptr_q] = c_FULL;
        end
        if (bus.FRAME_RELEASE_I) begin
            if (held_q) begin
                bank_d[held_bank_q] = c_EMPTY;
                held_d              = 1'b0;
            end else begin
                proto_err_d = 1'b1;
            end
        end
        if (w_frame_ready && bus.FRAME_ACK_I) begin
            bank_d[rd_ptr_q] = c_IN_USE;
            held_d           = 1'b1;
            held_bank_d      = rd_ptr_q;
            rd_ptr_d         = ~rd_ptr_q;
        end
    end

    always_comb begin
        w_frame_ready     = !held_q && (bank_q[rd_ptr_q] == c_FULL);
        bus.LOAD_START_O  = start_q;
        bus.LOAD_BANK_O   = wr_ptr_q;
        bus.FRAME_READY_O = w_frame_ready;
        bus.FRAME_BANK_O  = held_q ? held_bank_q : rd_ptr_q;
        bus.BUSY_O        = (state_q != c_IDLE);
        bus.TIMEOUT_O     = timeout_q;
        bus.PROTO_ERR_O   = proto_err_q;
        bus.FRAME_COUNT_O = count_q;
    end
endmodule

`default_nettype wire

// File: doc/frame_bank_scheduler.md
Name: frame_bank_scheduler

Overview:
- Sequences the 512-sample ROM-to-RAM frame loader across two ping-pong sample banks and hands filled banks to the downstream decoder stage.
- Issues one-cycle start pulses to the loader and tracks the loader's DONE level through a full load.
- Keeps per-bank ownership (EMPTY/FULL/IN_USE) and runs a ready/ack/release handshake with the consumer.
- Flags loader hangs with a watchdog.

Parameters:
- TIMEOUT_CYCLES, 1024, max cycles allowed in each wait state before fault; must be > 515.
- TIMEOUT_WIDTH, 11, width of watchdog counter; must hold TIMEOUT_CYCLES.
- COUNT_WIDTH, 16, width of FRAME_COUNT_O.

Ports:
- CLOCK_I  in  1  single clock, rising edge.
- RESET_I  in  1  asynchronous, active-high reset.
- ENABLE_I  in  1  level; permits new load launches.
- LOAD_DONE_I  in  1  loader DONE level; high = loader idle.
- LOAD_START_O  out  1  one-cycle start pulse to loader.
- LOAD_BANK_O  out  1  bank the current or next load writes into.
- FRAME_READY_O  out  1  a FULL bank is available to the consumer.
- FRAME_BANK_O  out  1  bank offered while ready; bank held while consumer owns one.
- FRAME_ACK_I  in  1  consumer takes offered bank; sampled only when FRAME_READY_O=1.
- FRAME_RELEASE_I  in  1  consumer returns its held bank.
- BUSY_O  out  1  FSM not in IDLE.
- TIMEOUT_O  out  1  sticky watchdog fault.
- PROTO_ERR_O  out  1  sticky; set by RELEASE with no held bank.
- FRAME_COUNT_O  out  COUNT_WIDTH  completed loads, wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Reset (async, RESET_I=1): state=IDLE; both banks EMPTY; wr_ptr=0, rd_ptr=0, held=0; all outputs 0 (LOAD_BANK_O=0, FRAME_BANK_O=0, FRAME_COUNT_O=0); watchdog=0. Reset mid-load abandons the load; the bank stays EMPTY.
- FSM states: IDLE, WAIT_LOW, WAIT_HIGH, FAULT.
- IDLE: if ENABLE_I=1 and bank[wr_ptr]=EMPTY and LOAD_DONE_I=1:
  - register LOAD_START_O=1 for exactly one cycle, asserted the cycle after the condition;
  - go to WAIT_LOW; clear watchdog.
- WAIT_LOW: LOAD_DONE_I=0 -> WAIT_HIGH, clear watchdog. Otherwise increment watchdog.
- WAIT_HIGH: LOAD_DONE_I=1 ->
  - bank[wr_ptr]=FULL;
  - wr_ptr toggles;
  - FRAME_COUNT_O+1;
  - go to IDLE.
  - Otherwise increment watchdog.
- Watchdog in WAIT_LOW or WAIT_HIGH reaching TIMEOUT_CYCLES: set TIMEOUT_O, go to FAULT; the bank stays EMPTY and wr_ptr is unchanged.
- FAULT: no launches. Exit to IDLE only when ENABLE_I=0. TIMEOUT_O stays set until reset.
- ENABLE_I deasserted mid-load: the load completes normally; no new launch follows.
- LOAD_BANK_O = wr_ptr (registered state).
- BUSY_O = (state != IDLE).
- Consumer side:
  - FRAME_READY_O = !held & (bank[rd_ptr]=FULL).
  - FRAME_BANK_O = rd_ptr when not held, held_bank when held.
  - READY & ACK at an edge: bank[rd_ptr]=IN_USE, held=1, held_bank=rd_ptr, rd_ptr toggles.
  - RELEASE while held: bank[held_bank]=EMPTY, held=0.
  - RELEASE while not held: ignored; set PROTO_ERR_O.
  - ACK while READY=0: ignored.
- Simultaneous events:
  - RELEASE and ACK in the same cycle: the release applies first. The ACK is honoured only if READY was 1 that cycle. Since READY=0 while held, the new bank is taken no earlier than the next cycle.
  - Load completion and RELEASE in the same cycle: both applied; they always target different banks.
- Ordering: banks are filled 0,1,0,1,... and consumed in the same order.
  - At most 2 FULL banks.
  - Launch stalls while bank[wr_ptr] != EMPTY.
- FRAME_COUNT_O wraps from 2^COUNT_WIDTH-1 to 0 with no flag.

Test Plan:
- Reset then ENABLE_I=1, loader model drops DONE 2 cycles after start and raises it 513 cycles later:
  - LOAD_START_O is a single-cycle pulse;
  - LOAD_BANK_O=0 during the load;
  - FRAME_READY_O=1 and FRAME_BANK_O=0 the cycle after DONE rises;
  - FRAME_COUNT_O=1.
- No consumer ACK, ENABLE_I held high: two loads complete (banks 0 then 1), then no further LOAD_START_O for 2000 cycles; FRAME_COUNT_O=2.
- Consumer ACKs bank 0, releases it 100 cycles later:
  - a third load starts into bank 0 within 2 cycles of the release;
  - FRAME_BANK_O=1 on the next offer.
- Loader never drops DONE after start: TIMEOUT_O=1 at TIMEOUT_CYCLES=1024 cycles after the pulse. With ENABLE_I held, no further pulses. Lowering ENABLE_I returns to IDLE with BUSY_O=0.
- FRAME_RELEASE_I with nothing held: PROTO_ERR_O=1, bank states unchanged. Same-cycle RELEASE and ACK while holding bank 0 with bank 1 FULL: bank 0 becomes EMPTY; bank 1 is acquired on the following cycle's ACK.
- RESET_I pulsed during WAIT_HIGH:
  - all outputs 0 immediately, without waiting for a clock edge;
  - after reset, the next launch targets bank 0.
